// File: rtl/fetch_align_pkg.sv
// Shared sizing, queue entry type and RVC length helper for fetch_align.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_align_pkg;

    localparam int XLEN       = 32;
    localparam int BUS_LEN    = 2;                  // 32-bit words per fetch line
    localparam int BUS_WID    = 32 * BUS_LEN;
    localparam int LINE_HW    = 2 * BUS_LEN;        // halfwords per fetch line
    localparam int DEPTH      = 16;                 // queue depth in halfwords, power of two
    localparam int IDX_W      = $clog2(DEPTH);
    localparam int PTR_W      = IDX_W + 1;          // extra wrap bit so full != empty
    localparam int SKIP_W     = $clog2(LINE_HW);
    localparam int PUSH_W     = $clog2(LINE_HW + 1);
    // Two lines of headroom: one line already in flight plus one arriving.
    localparam int FREE_LIMIT = DEPTH - 2 * LINE_HW;

    typedef struct packed {
        logic [15:0] hw;
        logic        err;
    } hw_ent_t;

    // RVC: low two bits 2'b11 mark a 32-bit instruction.
    function automatic logic is_len4(input logic [15:0] hw);
        return hw[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align_if.sv
// Fetch-line input, redirect and decode-side instruction handshake bundle.
// Latency: n/a (wiring only).
// Backpressure: buffer_free throttles fetch; ins_rdy stalls the instruction output.
// Ports: slave = fetch_align side, master = fetch manager / decode side.
interface fetch_align_if;
    import fetch_align_pkg::*;

    logic               jump_vld;
    logic [XLEN-1:0]    jump_pc;
    logic               buffer_free;
    logic               line_vld;
    logic [BUS_WID-1:0] line_data;
    logic               line_err;
    logic               ins_vld;
    logic               ins_rdy;
    logic [31:0]        ins_data;
    logic [XLEN-1:0]    ins_pc;
    logic               ins_len4;
    logic               ins_err;

    modport slave (
        input  jump_vld, jump_pc, line_vld, line_data, line_err, ins_rdy,
        output buffer_free, ins_vld, ins_data, ins_pc, ins_len4, ins_err
    );

    modport master (
        output jump_vld, jump_pc, line_vld, line_data, line_err, ins_rdy,
        input  buffer_free, ins_vld, ins_data, ins_pc, ins_len4, ins_err
    );

endinterface

// File: rtl/fetch_align_hw_queue.sv
// Halfword circular buffer: up to LINE_HW pushes and 0-2 pops per cycle.
// Latency: a push is visible at h0/h1 the cycle after it is written (no bypass).
// Backpressure: none internally; the caller must not push beyond free space.
// Ports: clk/rst, flush_i (pointer reset), push_* write port, pop_num_i, count_o/h0_o/h1_o.
module fetch_align_hw_queue
    import fetch_align_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      push_vld_i,
    input  logic [PUSH_W-1:0]         push_num_i,
    input  logic [LINE_HW-1:0][15:0]  push_hw_i,
    input  logic                      push_err_i,
    input  logic [1:0]                pop_num_i,
    output logic [PTR_W-1:0]          count_o,
    output hw_ent_t                   h0_o,
    output hw_ent_t                   h1_o
);

    hw_ent_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] free_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (push_vld_i ? PTR_W'(push_num_i) : '0);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_num_i);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only observed below count_o.
    always_ff @(posedge clk) begin
        if (push_vld_i && !flush_i) begin
            for (int i = 0; i < LINE_HW; i++) begin
                if (PUSH_W'(i) < push_num_i) begin
                    mem[wr_ptr_q[IDX_W-1:0] + IDX_W'(i)] <= '{hw: push_hw_i[i], err: push_err_i};
                end
            end
        end
    end

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign h0_o    = mem[rd_ptr_q[IDX_W-1:0]];
    assign h1_o    = mem[rd_ptr_q[IDX_W-1:0] + IDX_W'(1)];
    assign free_w  = PTR_W'(DEPTH) - count_o;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push_vld_i && !flush_i) |-> (PTR_W'(push_num_i) <= free_w));

endmodule

// File: rtl/fetch_align.sv
// Realigns fetched lines into one RV32IC instruction (16/32-bit) per cycle with its PC.
// Latency: a line is decodable the cycle after it is accepted; redirect applies next cycle.
// Backpressure: ins_rdy low holds the head instruction; buffer_free drops with < 2 lines of room.
// Ports: clk, rst (sync, active-high), bus (fetch_align_if.slave: jump, line, instruction handshake).
module fetch_align
    import fetch_align_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fetch_align_if.slave  bus
);

    logic [SKIP_W-1:0]         skip_q, skip_d;
    logic [XLEN-1:0]           pc_q, pc_d;
    logic                      lock_q, lock_d;

    logic [PTR_W-1:0]          count;
    hw_ent_t                   h0, h1;
    logic                      len4;
    logic                      ins_vld;
    logic                      fire;
    logic [1:0]                pop_num;
    logic                      wr_en;
    logic [PUSH_W-1:0]         push_num;
    logic [SKIP_W-1:0]         src_idx [LINE_HW];
    logic [LINE_HW-1:0][15:0]  push_hw;

    fetch_align_hw_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (bus.jump_vld),
        .push_vld_i (wr_en),
        .push_num_i (push_num),
        .push_hw_i  (push_hw),
        .push_err_i (bus.line_err),
        .pop_num_i  (pop_num),
        .count_o    (count),
        .h0_o       (h0),
        .h1_o       (h1)
    );

    always_comb begin
        // An errored head always issues alone as a 16-bit slot.
        len4    = is_len4(h0.hw) && !h0.err;
        ins_vld = (count != '0) && (!len4 || count >= PTR_W'(2));
        fire    = ins_vld && bus.ins_rdy && !bus.jump_vld;
        pop_num = fire ? (len4 ? 2'd2 : 2'd1) : 2'd0;

        wr_en    = bus.line_vld && !bus.jump_vld && !lock_q;
        // An error line contributes only its first wanted halfword.
        push_num = bus.line_err ? PUSH_W'(1) : PUSH_W'(LINE_HW) - PUSH_W'(skip_q);
        for (int i = 0; i < LINE_HW; i++) begin
            // Lanes past the line end wrap to garbage but are never written.
            src_idx[i] = skip_q + SKIP_W'(i);
            push_hw[i] = bus.line_data[{src_idx[i], 4'b0000} +: 16];
        end

        pc_d   = pc_q;
        skip_d = skip_q;
        lock_d = lock_q;
        if (bus.jump_vld) begin
            pc_d   = bus.jump_pc;
            skip_d = bus.jump_pc[SKIP_W:1];
            lock_d = 1'b0;
        end else begin
            if (fire) begin
                pc_d = pc_q + (len4 ? XLEN'(4) : XLEN'(2));
            end
            if (wr_en) begin
                skip_d = '0;
                if (bus.line_err) begin
                    lock_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_q <= '0;
            pc_q   <= '0;
            lock_q <= 1'b0;
        end else begin
            skip_q <= skip_d;
            pc_q   <= pc_d;
            lock_q <= lock_d;
        end
    end

    assign bus.ins_vld     = ins_vld;
    assign bus.ins_len4    = len4;
    assign bus.ins_data    = len4 ? {h1.hw, h0.hw} : {16'h0000, h0.hw};
    assign bus.ins_err     = ins_vld && (h0.err || (len4 && h1.err));
    assign bus.ins_pc      = pc_q;
    assign bus.buffer_free = (count <= PTR_W'(FREE_LIMIT)) && !lock_q;

endmodule
